series_demux: RTL and testbench

- Scatter side of the series-mux priority chain. The series mux gathers one bit from the lowest-indexed selected input.
- This block does the reverse. It takes a serial bit stream and writes successive bits into the positions enabled in a select mask, lowest index first.
- It then presents the assembled word on a parallel output with a valid/ready handshake.
- It sits between a serial link and the parallel In/Sel side of mux chains, so words can be reconstructed for loop-back checking.

---
 rtl/series_pkg.sv | 21 ++
 rtl/series_demux_lsb.sv | 23 ++
 rtl/series_demux.sv | 82 ++++++++
 tb/tb_series_demux.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/series_pkg.sv
// Shared types and width helpers for the series demux.
// State encoding and default geometry.
package series_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 100;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int ptr_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/series_demux_lsb.sv
// Lowest-set-bit priority encoder.
// Index 0 wins, matching the mux chain order.
module lsb_finder
  import series_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PTR_W = ptr_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vector,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  // scan downward so the lowest set bit is the last writer
  always_comb begin
    idx = '0;
    any = |vector;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vector[i]) idx = PTR_W'(i);
    end
  end

endmodule

// File: rtl/series_demux.sv
// Serial-to-parallel scatter into the positions of a select mask.
// Lowest selected index is filled first.
module series_demux
  import series_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Sel,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] y_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] fill_cnt
);

  localparam int PTR_W = ptr_w(WIDTH);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] mask_clr;
  logic [PTR_W-1:0] ptr;
  logic             ptr_any;
  logic             take;

  lsb_finder #(
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) u_lsb (
    .vector (mask_r),
    .idx    (ptr),
    .any    (ptr_any)
  );

  assign mask_clr  = mask_r & ~(WIDTH'(1) << ptr);
  assign bit_ready = (state == FILL);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign take      = bit_ready & bit_valid & ptr_any;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = (Sel != '0) ? FILL : DONE;
      FILL: if (take && mask_clr == '0) nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // word assembly, mask consumption and fill count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r   <= '0;
      y_out    <= '0;
      fill_cnt <= '0;
    end else if (state == IDLE && start) begin
      mask_r   <= Sel;
      y_out    <= '0;
      fill_cnt <= '0;
    end else if (take) begin
      y_out[ptr] <= bit_in;
      mask_r     <= mask_clr;
      fill_cnt   <= fill_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_series_demux.sv
// Directed and random checks of series_demux.
// Two instances: WIDTH=8 and the default width.
module tb_series_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, bit_in, bit_valid, out_ready;
  logic [7:0] sel;
  logic       bit_ready, out_valid, busy;
  logic [7:0] y;
  logic [3:0] fc;

  logic        start_w, bit_in_w, bit_valid_w, out_ready_w;
  logic [99:0] sel_w;
  logic        br_w, ov_w, busy_w;
  logic [99:0] y_w;
  logic [6:0]  fc_w;

  int n_chk = 0;
  int n_fail = 0;

  series_demux #(.WIDTH(8)) d8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Sel       (sel),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .y_out     (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .fill_cnt  (fc)
  );

  series_demux d100 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_w),
    .Sel       (sel_w),
    .bit_in    (bit_in_w),
    .bit_valid (bit_valid_w),
    .bit_ready (br_w),
    .y_out     (y_w),
    .out_valid (ov_w),
    .out_ready (out_ready_w),
    .busy      (busy_w),
    .fill_cnt  (fc_w)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scatter bit stream into the selected positions, lowest first
  function automatic logic [7:0] model_y(input logic [7:0] m,
                                         input logic [7:0] b);
    logic [7:0] r;
    int k;
    r = '0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        r[i] = b[k];
        k++;
      end
    end
    return r;
  endfunction

  // start a word, stream bits with an optional stall, check result
  task automatic feed(input string tag, input logic [7:0] s,
                      input logic [7:0] b, input int sa,
                      input int sl);
    int  pc, j, st, lat, elat;
    bit  saw, rdy;
    pc = $countones(s);
    sel = s;
    start = 1'b1;
    step();
    start = 1'b0;
    sel = 8'($urandom);
    lat = 1;
    j = 0;
    st = 0;
    saw = 1'b0;
    while (!out_valid && lat < 100) begin
      rdy = bit_ready;
      saw |= rdy;
      if (j == sa && st < sl) begin
        bit_valid = 1'b0;
        st++;
      end else begin
        bit_valid = 1'b1;
        bit_in = b[j%8];
      end
      step();
      if (bit_valid && rdy) j++;
      lat++;
    end
    bit_valid = 1'b0;
    elat = pc + ((sa < pc) ? sl : 0) + 1;
    chk({tag, "_lat"}, 128'(lat), 128'(elat));
    chk({tag, "_y"}, 128'(y), 128'(model_y(s, b)));
    chk({tag, "_cnt"}, 128'(fc), 128'(pc));
    chk({tag, "_rdy_done"}, 128'(bit_ready), 128'(0));
    if (pc == 0) chk({tag, "_no_rdy"}, 128'(saw), 128'(0));
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, 128'(out_valid), 128'(0));
    chk({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    logic [99:0] e100;
    logic [7:0]  rs, rb;
    rst_n = 1'b0;
    start = 0; bit_in = 0; bit_valid = 0; out_ready = 0; sel = 0;
    start_w = 0; bit_in_w = 0; bit_valid_w = 0; out_ready_w = 0;
    sel_w = '0;
    #2;
    chk("rst_y", 128'(y), 128'(0));
    chk("rst_cnt", 128'(fc), 128'(0));
    chk("rst_flags", 128'({bit_ready, out_valid, busy}), 128'(0));
    chk("rst_w", 128'({br_w, ov_w, busy_w, fc_w}), 128'(0));
    step();
    rst_n = 1'b1;
    step();

    feed("t1", 8'b1010_0101, 8'b0000_1101, 99, 0);
    retire("t1");
    feed("t2", 8'h00, 8'h00, 99, 0);
    chk("t2_ov", 128'(out_valid), 128'(1));
    retire("t2");
    feed("t3", 8'hFF, 8'b1101_0011, 4, 3);
    chk("t3_y_lit", 128'(y), 128'(8'b1101_0011));
    retire("t3");

    feed("t4", 8'h80, 8'h01, 99, 0);
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in = 1'b0;
      start = (i == 2);
      sel = 8'h01;
      step();
      chk("t4_hold_ov", 128'(out_valid), 128'(1));
      chk("t4_hold_y", 128'(y), 128'(8'h80));
    end
    bit_valid = 1'b0;
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    chk("t4_ov_low", 128'(out_valid), 128'(0));
    chk("t4_hs_start_ignored", 128'(busy), 128'(0));
    chk("t4_y_kept", 128'(y), 128'(8'h80));
    step();
    chk("t4_still_idle", 128'(busy), 128'(0));

    sel = 8'h0F;
    start = 1'b1;
    step();
    start = 1'b0;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    step();
    step();
    bit_valid = 1'b0;
    chk("t5_part_cnt", 128'(fc), 128'(2));
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_y", 128'(y), 128'(0));
    chk("t5_rst_cnt", 128'(fc), 128'(0));
    chk("t5_rst_flags", 128'({bit_ready, out_valid, busy}), 128'(0));
    #1 rst_n = 1'b1;
    step();
    feed("t5b", 8'h03, 8'h03, 99, 0);
    chk("t5b_y_lit", 128'(y), 128'(8'h03));
    retire("t5b");

    sel_w = '0;
    sel_w[0] = 1'b1;
    sel_w[99] = 1'b1;
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    bit_valid_w = 1'b1;
    bit_in_w = 1'b1;
    step();
    chk("t6_mid_rdy", 128'(br_w), 128'(1));
    step();
    bit_valid_w = 1'b0;
    e100 = '0;
    e100[0] = 1'b1;
    e100[99] = 1'b1;
    chk("t6_ov", 128'(ov_w), 128'(1));
    chk("t6_y", 128'(y_w), 128'(e100));
    chk("t6_cnt", 128'(fc_w), 128'(2));
    out_ready_w = 1'b1;
    step();
    out_ready_w = 1'b0;
    sel_w = '0;
    sel_w[99] = 1'b1;
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    bit_valid_w = 1'b1;
    step();
    bit_valid_w = 1'b0;
    e100 = '0;
    e100[99] = 1'b1;
    chk("t6b_ov", 128'(ov_w), 128'(1));
    chk("t6b_y", 128'(y_w), 128'(e100));
    chk("t6b_cnt", 128'(fc_w), 128'(1));

    for (int n = 0; n < 24; n++) begin
      rs = 8'($urandom);
      rb = 8'($urandom);
      feed("rnd", rs, rb, int'($urandom_range(0, 8)),
           int'($urandom_range(0, 3)));
      retire("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
